// File: rtl/egress_rr_sched.sv
// egress_rr_sched: round-robin egress scheduler. It merges NUM_OF_PORTS per-port
// FIFOs onto a single valid/ready egress stream. Each grant drains up to
// MAX_BURST words from one port. Read data lands in a 2-entry skid buffer whose
// head drives the egress outputs.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   arb_en          - allows new grants (an active burst always completes)
//   port_ready[i]   - port i FIFO non-empty
//   port_out        - port i data in slice [i*WORD_WIDTH +: WORD_WIDTH], one cycle after port_read[i]
//   port_read       - one-hot (or zero) pop strobe toward the port FIFOs
//   egr_data/egr_port/egr_last/egr_valid - egress word, its source port, end-of-grant marker
//   egr_ready       - downstream accept
//
// Optional build macro: EGR_STRICT_PRIO_EN - port 0 wins every arbitration it
// is ready for; the remaining ports rotate round-robin.
module egress_rr_sched #(
    parameter int NUM_OF_PORTS = 4,
    parameter int WORD_WIDTH   = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               arb_en,
    input  logic [NUM_OF_PORTS-1:0]            port_ready,
    input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
    output logic [NUM_OF_PORTS-1:0]            port_read,
    output logic [WORD_WIDTH-1:0]              egr_data,
    output logic                               egr_valid,
    input  logic                               egr_ready,
    output logic [$clog2(NUM_OF_PORTS)-1:0]    egr_port,
    output logic                               egr_last
);
    localparam int PW = $clog2(NUM_OF_PORTS);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             grant_q, last_grant_q, arb_idx;
    logic                      arb_hit, grant_now;
    logic [CW-1:0]             burst_cnt_q;
    logic                      rd_d1_q, rd_last_d1_q;
    logic                      can_issue, port_read_i, end_low, last_rd, mark_prev;
    logic                      xfer, space_ok;
    logic [2:0]                occ_lhs, occ_rhs;
    logic [WORD_WIDTH-1:0]     sel_word;

    logic [1:0][WORD_WIDTH-1:0] buf_data;
    logic [1:0][PW-1:0]         buf_port;
    logic [1:0]                 buf_last;
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0]                 occ_q;

    // Round-robin search starting at last_grant+1; walking k downward lets the
    // nearest ready port overwrite farther ones.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = NUM_OF_PORTS; k >= 1; k--) begin
            if (port_ready[(int'(last_grant_q) + k) % NUM_OF_PORTS]) begin
                arb_hit = 1'b1;
                arb_idx = PW'((int'(last_grant_q) + k) % NUM_OF_PORTS);
            end
        end
`ifdef EGR_STRICT_PRIO_EN
        // When port 0 is idle, the search above is already round-robin over the rest.
        if (port_ready[0]) begin
            arb_hit = 1'b1;
            arb_idx = '0;
        end
`endif
    end

    assign grant_now = (state_q == IDLE) && arb_en && arb_hit;
    assign xfer      = egr_valid && egr_ready;

    // A new read lands two edges from now. Buffered plus in-flight words,
    // minus what leaves this cycle, must stay below the two buffer entries.
    assign occ_lhs  = {1'b0, occ_q} + {2'b0, rd_d1_q};
    assign occ_rhs  = 3'd2 + {2'b0, xfer};
    assign space_ok = occ_lhs < occ_rhs;

    assign can_issue   = (state_q == BURST) && (burst_cnt_q < MAX_CNT) && space_ok;
    assign port_read_i = can_issue && port_ready[grant_q];
    assign end_low     = can_issue && !port_ready[grant_q];
    assign last_rd     = port_read_i && (burst_cnt_q == LAST_CNT);
    // Burst ended by an empty port: retro-tag the newest word of this burst.
    assign mark_prev   = end_low && (burst_cnt_q != '0);

    assign port_read = port_read_i ? (NUM_OF_PORTS'(1) << grant_q) : '0;
    assign sel_word  = port_out[grant_q*WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_now) state_d = BURST;
            BURST:   if (last_rd || end_low || burst_cnt_q >= MAX_CNT) state_d = FLUSH;
            FLUSH:   if (!rd_d1_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PW'(NUM_OF_PORTS - 1);
            burst_cnt_q  <= '0;
            rd_d1_q      <= 1'b0;
            rd_last_d1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_d1_q      <= port_read_i;
            rd_last_d1_q <= last_rd;
            if (grant_now) begin
                grant_q     <= arb_idx;
                burst_cnt_q <= '0;
            end else if (port_read_i) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
            if (state_q == FLUSH && !rd_d1_q) last_grant_q <= grant_q;
        end
    end

    // grant_q cannot change while a read is in flight (FLUSH waits for it),
    // so it is a valid tag for the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= '0;
            buf_port <= '0;
            buf_last <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (rd_d1_q) begin
                buf_data[wr_ptr_q] <= sel_word;
                buf_port[wr_ptr_q] <= grant_q;
                buf_last[wr_ptr_q] <= rd_last_d1_q | mark_prev;
                wr_ptr_q           <= ~wr_ptr_q;
            end else if (mark_prev && occ_q != 2'd0) begin
                buf_last[~wr_ptr_q] <= 1'b1;
            end
            if (xfer) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, rd_d1_q} - {1'b0, xfer};
        end
    end

    assign egr_valid = (occ_q != 2'd0);
    assign egr_data  = buf_data[rd_ptr_q];
    assign egr_port  = buf_port[rd_ptr_q];
    assign egr_last  = buf_last[rd_ptr_q];

endmodule

// File: doc/egress_rr_sched.md
EGRESS_RR_SCHED -- requirements
Module: egress_rr_sched

Interface
REQ-001 SHALL have parameter NUM_OF_PORTS, default 4, number of switch output ports arbitrated (2..8).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, data word width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum words drained per grant (1..15).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port arb_en, input, 1 bit: scheduler enable; new grants are issued only while high.
REQ-007 SHALL have port port_ready, input, NUM_OF_PORTS bits: bit i high means port i FIFO is non-empty.
REQ-008 SHALL have port port_out, input, NUM_OF_PORTS*WORD_WIDTH bits: port i data in slice [i*WORD_WIDTH +: WORD_WIDTH], valid the cycle after port_read[i].
REQ-009 SHALL have port port_read, output, NUM_OF_PORTS bits: one-cycle pop strobe per port, at most one bit high.
REQ-010 SHALL have port egr_data, output, WORD_WIDTH bits: merged egress word.
REQ-011 SHALL have port egr_valid, output, 1 bit: egr_data/egr_port/egr_last valid.
REQ-012 SHALL have port egr_ready, input, 1 bit: downstream accept; a word transfers when egr_valid and egr_ready are both high.
REQ-013 SHALL have port egr_port, output, clog2(NUM_OF_PORTS) bits: source port of egr_data.
REQ-014 SHALL have port egr_last, output, 1 bit: marks the final word of a grant.

Function
REQ-015 SHALL implement FSM states IDLE, BURST, FLUSH.
REQ-016 IDLE: when arb_en high and any port_ready bit high, SHALL grant the first ready port searching from (last_grant+1) mod NUM_OF_PORTS and SHALL enter BURST the next cycle.
REQ-017 BURST: SHALL assert port_read[grant] in a cycle only if port_ready[grant] is high, burst_cnt < MAX_BURST, and buffer occupancy + in-flight reads - transfers this cycle < 2.
REQ-018 BURST SHALL go to FLUSH when burst_cnt reaches MAX_BURST or port_ready[grant] is low in a cycle where a read would otherwise be issued.
REQ-019 FLUSH SHALL return to IDLE once no read is in flight; last_grant SHALL update to grant on that transition.
REQ-020 Read data SHALL be captured into a 2-entry FIFO buffer one cycle after port_read, tagged with port index; egr_* SHALL present the buffer head.
REQ-021 egr_last SHALL be high on the word of the final read of the burst, whether the burst ended by MAX_BURST or by port_ready falling.
REQ-022 If a burst ends on port_ready low with no further read, egr_last SHALL be set on the previously captured word; if that word has already transferred, a zero-length burst results and nothing extra SHALL be emitted.
REQ-023 egr_data and egr_port SHALL hold stable while egr_valid is high and egr_ready is low.
REQ-024 Deasserting arb_en SHALL NOT abort an active burst; it blocks only the next grant.
REQ-025 Best-case throughput SHALL be one word per cycle with egr_ready held high; grant-to-first-egr_valid latency SHALL be 3 cycles.

Reset
REQ-026 On rst_n low, SHALL immediately clear: FSM to IDLE, port_read=0, egr_valid=0, egr_data=0, egr_port=0, egr_last=0, buffer empty, burst_cnt=0, last_grant=NUM_OF_PORTS-1 (port 0 wins first).
REQ-027 Reset mid-burst SHALL discard buffered and in-flight words; no egr_valid SHALL follow release until a new grant.

Configuration
REQ-028 With macro EGR_STRICT_PRIO_EN defined, port 0 SHALL win every IDLE arbitration when port_ready[0] is high; other ports SHALL use round-robin among themselves.
REQ-029 Without EGR_STRICT_PRIO_EN, all ports SHALL be pure round-robin per REQ-016.

Verification
REQ-030 Port 1 holds 6 words, egr_ready=1, others empty -> bursts of 4 then 2 from port 1, egr_last on words 4 and 6, egr_port=1.
REQ-031 All 4 ports ready continuously after reset -> grant order 0,1,2,3,0; each burst 4 words, no gaps within a burst.
REQ-032 Burst active, egr_ready held low 5 cycles -> at most 2 port_read pulses issued, egr_data stable, no word lost or duplicated after egr_ready returns.
REQ-033 rst_n pulsed low during a port 2 burst -> all outputs 0 same cycle; after release port 0 granted first.
REQ-034 EGR_STRICT_PRIO_EN defined, ports 0 and 3 ready -> port 0 drained fully before port 3 is granted.
REQ-035 Port 2 with 2 words, port_ready[2] falls after second read -> exactly 2 words, egr_last on second, FSM returns to IDLE.
